// File: rtl/hwag_pkg.sv
// rtl/hwag_pkg.sv - shared state encoding and default wheel constants
// Purpose: tracker FSM state type and the default 60-2 wheel geometry.
package hwag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC_WAIT,
    RUN,
    ERROR
  } hwag_state_e;

  localparam int unsigned TEETH_TOTAL_DEF   = 60;
  localparam int unsigned TEETH_MISSING_DEF = 2;
  localparam int unsigned STEPS_LOG2_DEF    = 6;
  localparam int unsigned PERIOD_W_DEF      = 24;

endpackage

// File: rtl/hwag_step_gen.sv
// rtl/hwag_step_gen.sv - sub-tooth step timer with angle cap
// Purpose: counts clk cycles between angle steps and asks for one acnt
//          increment every step_period cycles until acnt reaches cap.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   restart_i      clears the timer and suppresses any step this cycle
//   step_period_i  cycles per step; 0 means no period known yet
//   acnt_i         current crank angle
//   cap_i          highest angle allowed before the next tooth edge
//   step_o         combinational request: increment acnt this cycle
module hwag_step_gen
  import hwag_pkg::*;
#(
  parameter int unsigned SP_W   = PERIOD_W_DEF - STEPS_LOG2_DEF,
  parameter int unsigned ACNT_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              restart_i,
  input  logic [SP_W-1:0]   step_period_i,
  input  logic [ACNT_W-1:0] acnt_i,
  input  logic [ACNT_W-1:0] cap_i,
  output logic              step_o
);

  logic [SP_W-1:0] timer_q, timer_d;
  logic            at_cap;
  logic            period_ok;
  logic            expire;

  always_comb begin
    at_cap    = (acnt_i >= cap_i);
    period_ok = (step_period_i != '0);
    expire    = period_ok && (timer_q == step_period_i - SP_W'(1));
    step_o    = !restart_i && !at_cap && expire;

    timer_d = timer_q;
    if (restart_i) begin
      timer_d = '0;
    end else if (at_cap || !period_ok) begin
      // Stalled at the cap (or no period yet): freeze until the next edge.
      timer_d = timer_q;
    end else if (expire) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + SP_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/hwag_tooth_tracker.sv
// rtl/hwag_tooth_tracker.sv - crank tooth tracker with interpolated angle
// Purpose: follows tooth edges once hwag_start is high, checks that the gap
//          recurs once per revolution and interpolates sub-tooth angle steps.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   hwag_start_i      tracking enable (level)
//   cap_edge_i        1-cycle strobe per filtered tooth edge
//   gap_found_i       marks cap_edge_i as the first edge after the gap
//   tooth_period_i    last tooth period in clk cycles, valid with cap_edge_i
//   err_clr_i         clears err_flag_o
//   sync_o            high while in RUN
//   tcnt_o            tooth number, 0 = first tooth after the gap
//   acnt_o            crank angle in steps
//   step_o            pulse per acnt increment
//   rev_o             pulse when tcnt wraps to 0
//   err_o             pulse on sync loss
//   err_flag_o        sticky error flag
module hwag_tooth_tracker
  import hwag_pkg::*;
#(
  parameter int unsigned TEETH_TOTAL   = TEETH_TOTAL_DEF,
  parameter int unsigned TEETH_MISSING = TEETH_MISSING_DEF,
  parameter int unsigned STEPS_LOG2    = STEPS_LOG2_DEF,
  parameter int unsigned PERIOD_W      = PERIOD_W_DEF,
  localparam int unsigned TCNT_W = $clog2(TEETH_TOTAL),
  localparam int unsigned ACNT_W = $clog2(TEETH_TOTAL << STEPS_LOG2)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                hwag_start_i,
  input  logic                cap_edge_i,
  input  logic                gap_found_i,
  input  logic [PERIOD_W-1:0] tooth_period_i,
  input  logic                err_clr_i,
  output logic                sync_o,
  output logic [TCNT_W-1:0]   tcnt_o,
  output logic [ACNT_W-1:0]   acnt_o,
  output logic                step_o,
  output logic                rev_o,
  output logic                err_o,
  output logic                err_flag_o
);

  localparam int unsigned SP_W = PERIOD_W - STEPS_LOG2;
  localparam logic [TCNT_W-1:0] TOOTH_LAST = TCNT_W'(TEETH_TOTAL - TEETH_MISSING - 1);
  localparam logic [ACNT_W-1:0] TOOTH_SPAN = ACNT_W'((1 << STEPS_LOG2) - 1);
  // The last real tooth also covers the missing teeth, up to the final step
  // of the revolution.
  localparam logic [ACNT_W-1:0] GAP_SPAN   = ACNT_W'(((TEETH_MISSING + 1) << STEPS_LOG2) - 1);

  hwag_state_e       state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [ACNT_W-1:0] acnt_q, acnt_d;
  logic [SP_W-1:0]   step_period_q, step_period_d;
  logic [SP_W-1:0]   period_shr;
  logic [ACNT_W-1:0] base, cap;
  logic              sync_q, sync_d;
  logic              step_q, step_d;
  logic              rev_q, rev_d;
  logic              err_q, err_d;
  logic              err_flag_q, err_flag_d;
  logic              is_last;
  logic              timer_restart;
  logic              step_fire;

  always_comb begin
    is_last    = (tcnt_q == TOOTH_LAST);
    base       = ACNT_W'(tcnt_q) << STEPS_LOG2;
    cap        = base + (is_last ? GAP_SPAN : TOOTH_SPAN);
    period_shr = SP_W'(tooth_period_i >> STEPS_LOG2);

    // The gap tooth is several teeth long, so its period is never latched.
    step_period_d = step_period_q;
    if (cap_edge_i && !gap_found_i) begin
      step_period_d = (period_shr == '0) ? SP_W'(1) : period_shr;
    end

    timer_restart = cap_edge_i || (state_q != RUN) || !hwag_start_i;
  end

  hwag_step_gen #(
    .SP_W   (SP_W),
    .ACNT_W (ACNT_W)
  ) u_step_gen (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .restart_i     (timer_restart),
    .step_period_i (step_period_q),
    .acnt_i        (acnt_q),
    .cap_i         (cap),
    .step_o        (step_fire)
  );

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    acnt_d  = acnt_q;
    step_d  = 1'b0;
    rev_d   = 1'b0;
    err_d   = 1'b0;

    if (!hwag_start_i) begin
      state_d = IDLE;
      tcnt_d  = '0;
      acnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = SYNC_WAIT;
        SYNC_WAIT: begin
          if (cap_edge_i && gap_found_i) begin
            state_d = RUN;
            tcnt_d  = '0;
            acnt_d  = '0;
          end
        end
        RUN: begin
          if (cap_edge_i) begin
            if (gap_found_i && is_last) begin
              tcnt_d = '0;
              acnt_d = '0;
              rev_d  = 1'b1;
            end else if (!gap_found_i && !is_last) begin
              tcnt_d = tcnt_q + TCNT_W'(1);
              acnt_d = ACNT_W'(tcnt_q + TCNT_W'(1)) << STEPS_LOG2;
            end else begin
              // Early gap or missing gap: hold position, resynchronise.
              state_d = ERROR;
              err_d   = 1'b1;
            end
          end else if (step_fire) begin
            acnt_d = acnt_q + ACNT_W'(1);
            step_d = 1'b1;
          end
        end
        ERROR:   state_d = SYNC_WAIT;
        default: state_d = IDLE;
      endcase
    end

    sync_d = (state_d == RUN);
    // A new error (or one still visible on err_o) outranks a clear.
    err_flag_d = err_d || err_q || (err_flag_q && !err_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      tcnt_q        <= '0;
      acnt_q        <= '0;
      step_period_q <= '0;
      sync_q        <= 1'b0;
      step_q        <= 1'b0;
      rev_q         <= 1'b0;
      err_q         <= 1'b0;
      err_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      acnt_q        <= acnt_d;
      step_period_q <= step_period_d;
      sync_q        <= sync_d;
      step_q        <= step_d;
      rev_q         <= rev_d;
      err_q         <= err_d;
      err_flag_q    <= err_flag_d;
    end
  end

  assign sync_o     = sync_q;
  assign tcnt_o     = tcnt_q;
  assign acnt_o     = acnt_q;
  assign step_o     = step_q;
  assign rev_o      = rev_q;
  assign err_o      = err_q;
  assign err_flag_o = err_flag_q;

endmodule

// File: tb/tb_hwag_tooth_tracker.sv
// tb/tb_hwag_tooth_tracker.sv - self-checking bench for hwag_tooth_tracker
module tb_hwag_tooth_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        hwag_start;
  logic        cap_edge;
  logic        gap_found;
  logic [23:0] tooth_period;
  logic        err_clr;
  logic        sync;
  logic [5:0]  tcnt;
  logic [11:0] acnt;
  logic        step;
  logic        rev;
  logic        err;
  logic        err_flag;

  int n_cmp = 0;
  int n_bad = 0;
  int q_step[$];
  int q_rev[$];
  int q_err[$];
  int m_sp;
  int m_acnt;
  int rev_seen = 0;

  always #5 clk = ~clk;

  hwag_tooth_tracker dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .hwag_start_i   (hwag_start),
    .cap_edge_i     (cap_edge),
    .gap_found_i    (gap_found),
    .tooth_period_i (tooth_period),
    .err_clr_i      (err_clr),
    .sync_o         (sync),
    .tcnt_o         (tcnt),
    .acnt_o         (acnt),
    .step_o         (step),
    .rev_o          (rev),
    .err_o          (err),
    .err_flag_o     (err_flag)
  );

  // Output monitor: pops expected pulse data when the DUT produces pulses.
  always @(negedge clk) begin
    int e;
    if (rst === 1'b0) begin
      if (step === 1'b1) begin
        n_cmp++;
        if (q_step.size() == 0) begin
          n_bad++;
          $display("FAIL step_extra: step at acnt=%0d, required no step", acnt);
        end else begin
          e = q_step.pop_front();
          if (int'(acnt) !== e) begin
            n_bad++;
            $display("FAIL step_acnt: acnt=%0d, required %0d", acnt, e);
          end
        end
      end
      if (rev === 1'b1) begin
        rev_seen++;
        n_cmp++;
        if (q_rev.size() == 0) begin
          n_bad++;
          $display("FAIL rev_extra: rev at tcnt=%0d, required no rev", tcnt);
        end else begin
          void'(q_rev.pop_front());
          if (tcnt !== 6'd0 || acnt !== 12'd0) begin
            n_bad++;
            $display("FAIL rev_pos: tcnt=%0d acnt=%0d, required 0/0", tcnt, acnt);
          end
        end
      end
      if (err === 1'b1) begin
        n_cmp++;
        if (q_err.size() == 0) begin
          n_bad++;
          $display("FAIL err_extra: err at tcnt=%0d, required no err", tcnt);
        end else begin
          void'(q_err.pop_front());
          if (err_flag !== 1'b1) begin
            n_bad++;
            $display("FAIL err_flag_set: err_flag=%0b, required 1", err_flag);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One tooth edge followed by (spacing-1) idle cycles. Expected steps for
  // the tooth are derived from the latched period and the edge spacing.
  task automatic drive_edge(input bit gap, input int period, input int spacing,
                            input int exp_tcnt, input bit exp_sync,
                            input bit exp_err, input bit exp_rev);
    int base;
    int capn;
    int n;
    int held;
    held = m_acnt;
    base = exp_tcnt * 64;
    cap_edge     = 1'b1;
    gap_found    = gap;
    tooth_period = 24'(period);
    if (!gap) m_sp = (period / 64 < 1) ? 1 : period / 64;
    if (exp_err) begin
      q_err.push_back(1);
    end else if (exp_sync) begin
      capn = (exp_tcnt == 57) ? 191 : 63;
      n = (m_sp == 0) ? 0 : (spacing - 1) / m_sp;
      if (n > capn) n = capn;
      for (int k = 1; k <= n; k++) q_step.push_back(base + k);
      m_acnt = base + n;
      if (exp_rev) q_rev.push_back(1);
    end
    tick();
    cap_edge  = 1'b0;
    gap_found = 1'b0;
    n_cmp++;
    if (int'(tcnt) !== exp_tcnt) begin
      n_bad++;
      $display("FAIL edge_tcnt: tcnt=%0d, required %0d", tcnt, exp_tcnt);
    end
    n_cmp++;
    if (sync !== exp_sync) begin
      n_bad++;
      $display("FAIL edge_sync: sync=%0b, required %0b (tcnt %0d)", sync, exp_sync, exp_tcnt);
    end
    if (exp_err || exp_sync) begin
      n_cmp++;
      if (int'(acnt) !== (exp_err ? held : base)) begin
        n_bad++;
        $display("FAIL edge_acnt: acnt=%0d, required %0d", acnt, exp_err ? held : base);
      end
    end
    repeat (spacing - 1) tick();
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (q_step.size() != 0 || q_rev.size() != 0 || q_err.size() != 0) begin
      n_bad++;
      $display("FAIL %s_pending: step/rev/err left %0d/%0d/%0d, required 0/0/0",
               name, q_step.size(), q_rev.size(), q_err.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hwag_start = 1'b0; cap_edge = 1'b0; gap_found = 1'b0;
    tooth_period = '0; err_clr = 1'b0;
    m_sp = 0; m_acnt = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({sync, step, rev, err, err_flag} !== 5'b0 || tcnt !== 6'd0 || acnt !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: sync/step/rev/err/flag=%b tcnt=%0d acnt=%0d, required all 0",
               {sync, step, rev, err, err_flag}, tcnt, acnt);
    end
  endtask

  task automatic test_first_sync();
    hwag_start = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (sync !== 1'b0) begin
      n_bad++;
      $display("FAIL presync: sync=%0b, required 0", sync);
    end
    drive_edge(1'b1, 3000, 1000, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_rotation();
    int r0;
    r0 = rev_seen;
    for (int t = 1; t <= 57; t++) drive_edge(1'b0, 1000, (t == 57) ? 3000 : 1000, t, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (acnt !== 12'd3839) begin
      n_bad++;
      $display("FAIL gap_tooth_end: acnt=%0d, required 3839", acnt);
    end
    drive_edge(1'b1, 3000, 20, 0, 1'b1, 1'b0, 1'b1);
    // Faster lap; tooth 5 edge lands on the timer expiry of its second step.
    for (int t = 1; t <= 57; t++)
      drive_edge(1'b0, 1000, (t == 5) ? 30 : ((t == 57) ? 60 : 20), t, 1'b1, 1'b0, 1'b0);
    drive_edge(1'b1, 3000, 20, 0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (rev_seen - r0 !== 2) begin
      n_bad++;
      $display("FAIL rev_count: revs=%0d, required 2", rev_seen - r0);
    end
    check_drained("rotation");
  endtask

  task automatic test_early_gap();
    for (int t = 1; t <= 29; t++) drive_edge(1'b0, 1000, 20, t, 1'b1, 1'b0, 1'b0);
    drive_edge(1'b1, 1000, 20, 29, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (err_flag !== 1'b1 || sync !== 1'b0) begin
      n_bad++;
      $display("FAIL early_gap_state: err_flag=%0b sync=%0b, required 1/0", err_flag, sync);
    end
    drive_edge(1'b0, 1000, 20, 29, 1'b0, 1'b0, 1'b0);
    drive_edge(1'b1, 3000, 20, 0, 1'b1, 1'b0, 1'b0);
    check_drained("early_gap");
  endtask

  task automatic test_missing_gap();
    for (int t = 1; t <= 57; t++) drive_edge(1'b0, 1000, 20, t, 1'b1, 1'b0, 1'b0);
    drive_edge(1'b0, 1000, 20, 57, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (err_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL missing_gap_flag: err_flag=%0b, required 1", err_flag);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (err_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clr: err_flag=%0b, required 0", err_flag);
    end
    drive_edge(1'b1, 3000, 20, 0, 1'b1, 1'b0, 1'b0);
    check_drained("missing_gap");
  endtask

  task automatic test_fast_period();
    drive_edge(1'b0, 40, 100, 1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (acnt !== 12'd127 || step !== 1'b0) begin
      n_bad++;
      $display("FAIL p40_stall: acnt=%0d step=%0b, required 127/0", acnt, step);
    end
    drive_edge(1'b0, 20, 100, 2, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (acnt !== 12'd191) begin
      n_bad++;
      $display("FAIL p20_stall: acnt=%0d, required 191", acnt);
    end
    check_drained("fast_period");
  endtask

  task automatic test_start_drop();
    drive_edge(1'b1, 1000, 20, 2, 1'b0, 1'b1, 1'b0);
    drive_edge(1'b1, 3000, 30, 0, 1'b1, 1'b0, 1'b0);
    drive_edge(1'b0, 1000, 20, 1, 1'b1, 1'b0, 1'b0);
    hwag_start = 1'b0;
    tick();
    n_cmp++;
    if (sync !== 1'b0 || tcnt !== 6'd0 || acnt !== 12'd0 || step !== 1'b0 || err_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL start_drop: sync=%0b tcnt=%0d acnt=%0d step=%0b flag=%0b, required 0/0/0/0/1",
               sync, tcnt, acnt, step, err_flag);
    end
    m_acnt = 0;
    repeat (5) tick();
    check_drained("start_drop");
  endtask

  task automatic test_reset_mid();
    hwag_start = 1'b1;
    tick();
    tick();
    drive_edge(1'b1, 3000, 20, 0, 1'b1, 1'b0, 1'b0);
    drive_edge(1'b0, 1000, 20, 1, 1'b1, 1'b0, 1'b0);
    check_drained("reset_mid");
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sync, step, rev, err, err_flag} !== 5'b0 || tcnt !== 6'd0 || acnt !== 12'd0) begin
      n_bad++;
      $display("FAIL async_reset: sync/step/rev/err/flag=%b tcnt=%0d acnt=%0d, required all 0",
               {sync, step, rev, err, err_flag}, tcnt, acnt);
    end
    m_sp = 0;
    m_acnt = 0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_sync();
    test_rotation();
    test_early_gap();
    test_missing_gap();
    test_fast_period();
    test_start_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
